// File: rtl/inst_mem_loadable.sv
// Runtime-loadable synchronous-read instruction memory with a valid/ready program load port.
// Define INST_MEM_CLEAR_EN to sweep every word to NOP_WORD after reset.
module inst_mem_loadable #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       DEPTH     = 32,
   parameter int unsigned       ADDR_W    = $clog2(DEPTH),
   parameter logic [DATA_W-1:0] NOP_WORD  = 32'h1000_0000,
   parameter logic [DATA_W-1:0] HALT_WORD = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_read,
   input  logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] inst,
   output logic              inst_valid,
   input  logic              load_start,
   input  logic [ADDR_W-1:0] load_base,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              busy,
   output logic [ADDR_W:0]   load_count,
   output logic              load_err
);

   typedef enum logic [1:0] {CLEAR, IDLE, LOAD} state_t;

`ifdef INST_MEM_CLEAR_EN
   localparam state_t RST_STATE = CLEAR;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   // One extra bit so DEPTH itself is representable for range checks.
   localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH-1);

   state_t            state, state_n;
   logic [ADDR_W-1:0] ptr, ptr_n;
   logic [DATA_W-1:0] inst_n;
   logic              inst_valid_n;
   logic [ADDR_W:0]   load_count_n;
   logic              load_err_n;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] mem [DEPTH];

   always_comb begin
      state_n      = state;
      ptr_n        = ptr;
      inst_n       = inst;
      inst_valid_n = 1'b0;
      load_count_n = load_count;
      load_err_n   = load_err;
      wr_en        = 1'b0;
      wr_addr      = ptr;
      wr_data      = NOP_WORD;
      case (state)
         CLEAR: begin
            // ptr doubles as the sweep counter
            wr_en = 1'b1;
            ptr_n = ptr + 1'b1;
            if (ptr == LAST_ADDR) begin
               state_n = IDLE;
               ptr_n   = '0;
            end
         end
         IDLE: begin
            if (en_read) begin
               inst_n       = ({1'b0, pc} < DEPTH_X) ? mem[pc] : HALT_WORD;
               inst_valid_n = 1'b1;
            end
            if (load_start) begin
               load_count_n = '0;
               if ({1'b0, load_base} < DEPTH_X) begin
                  load_err_n = 1'b0;
                  ptr_n      = load_base;
                  state_n    = LOAD;
               end else begin
                  load_err_n = 1'b1;
               end
            end
         end
         LOAD: begin
            if (load_valid) begin
               wr_en        = 1'b1;
               wr_data      = load_data;
               ptr_n        = ptr + 1'b1;
               load_count_n = load_count + 1'b1;
               if (load_last) begin
                  state_n = IDLE;
               end else if (ptr == LAST_ADDR) begin
                  load_err_n = 1'b1;
                  state_n    = IDLE;
               end
            end
         end
         default: state_n = RST_STATE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RST_STATE;
         ptr        <= '0;
         inst       <= NOP_WORD;
         inst_valid <= 1'b0;
         load_count <= '0;
         load_err   <= 1'b0;
      end else begin
         state      <= state_n;
         ptr        <= ptr_n;
         inst       <= inst_n;
         inst_valid <= inst_valid_n;
         load_count <= load_count_n;
         load_err   <= load_err_n;
      end
   end

   // Reset blocks writes so an aborted load leaves earlier words intact.
   always_ff @(posedge clk) begin
      if (wr_en && !rst)
         mem[wr_addr] <= wr_data;
   end

   assign load_ready = (state == LOAD);
   assign busy       = (state != IDLE);

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable: a DEPTH=32 instance for load/fetch scenarios and a
// DEPTH=20 instance for out-of-range fetch and load boundaries.
module tb_inst_mem_loadable;

`ifdef INST_MEM_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   localparam logic [31:0] NOP  = 32'h1000_0000;
   localparam logic [31:0] HALT = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   int unsigned vectors = 0;
   int unsigned miscompares = 0;

   logic [31:0] gcd [23] = '{
      32'h4000_03ED, 32'h4100_0024, 32'h4200_0018, 32'h6012_0000, 32'h8000_0009,
      32'h7012_0000, 32'hA000_0006, 32'h5112_0000, 32'h9000_0003, 32'h5221_0000,
      32'h9000_0003, 32'h3010_0000, 32'h2000_001F, 32'h1000_0000, 32'h1000_0000,
      32'h4300_0001, 32'h5331_0000, 32'h2000_001E, 32'h1000_0000, 32'h1000_0000,
      32'h1000_0000, 32'h1000_0000, 32'h0000_0000};

   // DEPTH=32 instance
   logic        en_read_a, load_start_a, load_valid_a, load_last_a;
   logic [4:0]  pc_a, load_base_a;
   logic [31:0] inst_a, load_data_a;
   logic        inst_valid_a, load_ready_a, busy_a, load_err_a;
   logic [5:0]  load_count_a;

   // DEPTH=20 instance
   logic        en_read_b, load_start_b, load_valid_b, load_last_b;
   logic [4:0]  pc_b, load_base_b;
   logic [31:0] inst_b, load_data_b;
   logic        inst_valid_b, load_ready_b, busy_b, load_err_b;
   logic [5:0]  load_count_b;

   inst_mem_loadable #(.DATA_W(32), .DEPTH(32)) dut_a (
      .clk(clk), .rst(rst), .en_read(en_read_a), .pc(pc_a), .inst(inst_a),
      .inst_valid(inst_valid_a), .load_start(load_start_a), .load_base(load_base_a),
      .load_valid(load_valid_a), .load_data(load_data_a), .load_last(load_last_a),
      .load_ready(load_ready_a), .busy(busy_a), .load_count(load_count_a), .load_err(load_err_a));

   inst_mem_loadable #(.DATA_W(32), .DEPTH(20)) dut_b (
      .clk(clk), .rst(rst), .en_read(en_read_b), .pc(pc_b), .inst(inst_b),
      .inst_valid(inst_valid_b), .load_start(load_start_b), .load_base(load_base_b),
      .load_valid(load_valid_b), .load_data(load_data_b), .load_last(load_last_b),
      .load_ready(load_ready_b), .busy(busy_b), .load_count(load_count_b), .load_err(load_err_b));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      en_read_a = 0; pc_a = '0; load_start_a = 0; load_base_a = '0;
      load_valid_a = 0; load_data_a = '0; load_last_a = 0;
      en_read_b = 0; pc_b = '0; load_start_b = 0; load_base_b = '0;
      load_valid_b = 0; load_data_b = '0; load_last_b = 0;
      rst = 1;
      tick(); tick();
      vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL reset_inst: got %h want %h", inst_a, NOP); end
      vectors++; if (inst_valid_a !== 1'b0) begin miscompares++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid_a); end
      vectors++; if (load_ready_a !== 1'b0) begin miscompares++; $display("FAIL reset_load_ready: got %b want 0", load_ready_a); end
      vectors++; if (load_count_a !== 6'd0) begin miscompares++; $display("FAIL reset_load_count: got %0d want 0", load_count_a); end
      vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL reset_load_err: got %b want 0", load_err_a); end
      vectors++; if (busy_a !== CLR) begin miscompares++; $display("FAIL reset_busy: got %b want %b", busy_a, CLR); end
      rst = 0;
   endtask

   task automatic test_clear();
      if (CLR) begin
         for (int i = 1; i <= 32; i++) begin
            tick();
            if (i == 31) begin
               vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL clear_busy_31: got %b want 1", busy_a); end
            end
         end
         vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL clear_busy_32: got %b want 0", busy_a); end
         vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL clear_busy_b: got %b want 0", busy_b); end
         en_read_a = 1; pc_a = 5'd7;
         tick();
         vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL clear_fetch7: got %h want %h", inst_a, NOP); end
         vectors++; if (inst_valid_a !== 1'b1) begin miscompares++; $display("FAIL clear_fetch7_valid: got %b want 1", inst_valid_a); end
         en_read_a = 0;
         tick();
         vectors++; if (inst_valid_a !== 1'b0) begin miscompares++; $display("FAIL clear_valid_pulse: got %b want 0", inst_valid_a); end
      end else begin
         tick();
         vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL noclear_busy: got %b want 0", busy_a); end
      end
   endtask

   task automatic test_load_gcd();
      load_start_a = 1; load_base_a = 5'd0;
      tick();
      load_start_a = 0;
      vectors++; if (load_ready_a !== 1'b1) begin miscompares++; $display("FAIL gcd_ready: got %b want 1", load_ready_a); end
      for (int i = 0; i < 23; i++) begin
         load_valid_a = 1; load_data_a = gcd[i]; load_last_a = (i == 22);
         tick();
      end
      load_valid_a = 0; load_last_a = 0;
      vectors++; if (load_count_a !== 6'd23) begin miscompares++; $display("FAIL gcd_count: got %0d want 23", load_count_a); end
      vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL gcd_busy: got %b want 0", busy_a); end
      vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL gcd_err: got %b want 0", load_err_a); end
      en_read_a = 1; pc_a = 5'd1;
      tick();
      vectors++; if (inst_a !== 32'h4100_0024) begin miscompares++; $display("FAIL gcd_fetch1: got %h want %h", inst_a, 32'h4100_0024); end
      pc_a = 5'd22;
      tick();
      vectors++; if (inst_a !== 32'h0000_0000) begin miscompares++; $display("FAIL gcd_fetch22: got %h want 0", inst_a); end
      vectors++; if (inst_valid_a !== 1'b1) begin miscompares++; $display("FAIL gcd_b2b_valid: got %b want 1", inst_valid_a); end
      en_read_a = 0;
   endtask

   task automatic test_overrun();
      load_start_a = 1; load_base_a = 5'd30;
      tick();
      load_start_a = 0;
      load_valid_a = 1; load_data_a = 32'hAAAA_001E; tick();
      load_data_a = 32'hAAAA_001F; tick();
      vectors++; if (load_err_a !== 1'b1) begin miscompares++; $display("FAIL ovr_err: got %b want 1", load_err_a); end
      vectors++; if (load_count_a !== 6'd2) begin miscompares++; $display("FAIL ovr_count: got %0d want 2", load_count_a); end
      vectors++; if (load_ready_a !== 1'b0) begin miscompares++; $display("FAIL ovr_ready: got %b want 0", load_ready_a); end
      load_data_a = 32'hAAAA_0020; tick();
      load_data_a = 32'hAAAA_0021; tick();
      load_valid_a = 0;
      vectors++; if (load_count_a !== 6'd2) begin miscompares++; $display("FAIL ovr_count_after: got %0d want 2", load_count_a); end
      en_read_a = 1; pc_a = 5'd30; tick();
      vectors++; if (inst_a !== 32'hAAAA_001E) begin miscompares++; $display("FAIL ovr_fetch30: got %h want %h", inst_a, 32'hAAAA_001E); end
      pc_a = 5'd31; tick();
      vectors++; if (inst_a !== 32'hAAAA_001F) begin miscompares++; $display("FAIL ovr_fetch31: got %h want %h", inst_a, 32'hAAAA_001F); end
      pc_a = 5'd0; tick();
      vectors++; if (inst_a !== gcd[0]) begin miscompares++; $display("FAIL ovr_nowrap0: got %h want %h", inst_a, gcd[0]); end
      en_read_a = 0; tick();
   endtask

   task automatic test_small_depth();
      en_read_b = 1; pc_b = 5'd25;
      tick();
      en_read_b = 0;
      vectors++; if (inst_b !== HALT) begin miscompares++; $display("FAIL small_halt: got %h want %h", inst_b, HALT); end
      vectors++; if (inst_valid_b !== 1'b1) begin miscompares++; $display("FAIL small_halt_valid: got %b want 1", inst_valid_b); end
      load_start_b = 1; load_base_b = 5'd21;
      tick();
      load_start_b = 0;
      vectors++; if (load_err_b !== 1'b1) begin miscompares++; $display("FAIL small_base_err: got %b want 1", load_err_b); end
      vectors++; if (busy_b !== 1'b0) begin miscompares++; $display("FAIL small_base_idle: got %b want 0", busy_b); end
      load_start_b = 1; load_base_b = 5'd19;
      tick();
      load_start_b = 0;
      vectors++; if (load_err_b !== 1'b0) begin miscompares++; $display("FAIL small_err_clr: got %b want 0", load_err_b); end
      load_valid_b = 1; load_data_b = 32'h5555_0013;
      tick();
      load_valid_b = 0;
      vectors++; if (load_err_b !== 1'b1) begin miscompares++; $display("FAIL small_last_err: got %b want 1", load_err_b); end
      vectors++; if (load_count_b !== 6'd1) begin miscompares++; $display("FAIL small_last_count: got %0d want 1", load_count_b); end
      en_read_b = 1; pc_b = 5'd19;
      tick();
      en_read_b = 0;
      vectors++; if (inst_b !== 32'h5555_0013) begin miscompares++; $display("FAIL small_fetch19: got %h want %h", inst_b, 32'h5555_0013); end
   endtask

   task automatic test_back_to_back();
      load_start_a = 1; load_base_a = 5'd10;
      tick();
      load_start_a = 0;
      en_read_a = 1; pc_a = 5'd3;
      tick();
      en_read_a = 0;
      vectors++; if (inst_a !== gcd[0]) begin miscompares++; $display("FAIL load_fetch_hold: got %h want %h", inst_a, gcd[0]); end
      vectors++; if (inst_valid_a !== 1'b0) begin miscompares++; $display("FAIL load_fetch_valid: got %b want 0", inst_valid_a); end
      load_valid_a = 1; load_data_a = 32'hDEAD_0010; load_last_a = 1;
      tick();
      load_valid_a = 0; load_last_a = 0;
      vectors++; if (load_count_a !== 6'd1) begin miscompares++; $display("FAIL b2b_count: got %0d want 1", load_count_a); end
      en_read_a = 1; pc_a = 5'd10; load_start_a = 1; load_base_a = 5'd10;
      tick();
      en_read_a = 0; load_start_a = 0;
      vectors++; if (inst_a !== 32'hDEAD_0010) begin miscompares++; $display("FAIL same_cycle_old: got %h want %h", inst_a, 32'hDEAD_0010); end
      vectors++; if (load_ready_a !== 1'b1) begin miscompares++; $display("FAIL same_cycle_load: got %b want 1", load_ready_a); end
      load_valid_a = 1; load_data_a = 32'hBEEF_0010; load_last_a = 1;
      tick();
      load_valid_a = 0; load_last_a = 0;
      en_read_a = 1; pc_a = 5'd10;
      tick();
      en_read_a = 0;
      vectors++; if (inst_a !== 32'hBEEF_0010) begin miscompares++; $display("FAIL same_cycle_new: got %h want %h", inst_a, 32'hBEEF_0010); end
   endtask

   task automatic test_reset_mid_load();
      logic [31:0] exp13, exp15;
      load_start_a = 1; load_base_a = 5'd12;
      tick();
      load_start_a = 0;
      for (int i = 0; i < 3; i++) begin
         load_valid_a = 1; load_data_a = 32'hC0DE_000C + i;
         tick();
      end
      vectors++; if (load_count_a !== 6'd3) begin miscompares++; $display("FAIL mid_count: got %0d want 3", load_count_a); end
      rst = 1; load_data_a = 32'hFFFF_FFFF;
      tick();
      load_valid_a = 0;
      vectors++; if (load_count_a !== 6'd0) begin miscompares++; $display("FAIL mid_rst_count: got %0d want 0", load_count_a); end
      vectors++; if (load_err_a !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b want 0", load_err_a); end
      vectors++; if (inst_a !== NOP) begin miscompares++; $display("FAIL mid_rst_inst: got %h want %h", inst_a, NOP); end
      vectors++; if (load_ready_a !== 1'b0) begin miscompares++; $display("FAIL mid_rst_ready: got %b want 0", load_ready_a); end
      vectors++; if (busy_a !== CLR) begin miscompares++; $display("FAIL mid_rst_busy: got %b want %b", busy_a, CLR); end
      rst = 0;
      if (CLR) for (int i = 0; i < 32; i++) tick();
      exp13 = CLR ? NOP : 32'hC0DE_000D;
      exp15 = CLR ? NOP : gcd[15];
      en_read_a = 1; pc_a = 5'd13;
      tick();
      vectors++; if (inst_a !== exp13) begin miscompares++; $display("FAIL mid_fetch13: got %h want %h", inst_a, exp13); end
      pc_a = 5'd15;
      tick();
      en_read_a = 0;
      vectors++; if (inst_a !== exp15) begin miscompares++; $display("FAIL mid_fetch15: got %h want %h", inst_a, exp15); end
   endtask

   initial begin
      test_reset();
      test_clear();
      test_load_gcd();
      test_overrun();
      test_small_depth();
      test_back_to_back();
      test_reset_mid_load();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/inst_mem_loadable.md
# inst_mem_loadable

Parametrised, runtime-loadable instruction memory for the RISC 32-bit core. It replaces fixed, initial-block program ROMs with a synchronous-read instruction store that the fetch stage reads by PC, plus a valid/ready load port so a testbench or host can stream a program (e.g. the GCD routine) into any base address without re-elaboration. An optional post-reset sweep fills every word with NOP so unloaded locations execute harmlessly.

## Interface
- DATA_W, 32, instruction word width
- DEPTH, 32, number of instruction words (need not be a power of two)
- ADDR_W, $clog2(DEPTH), width of pc and load_base
- NOP_WORD, 32'h1000_0000, no-operation encoding
- HALT_WORD, 32'h0000_0000, halt encoding returned for out-of-range fetch

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- en_read  in  1  fetch request, sampled in IDLE only
- pc  in  ADDR_W  fetch address (word index)
- inst  out  DATA_W  registered fetched instruction
- inst_valid  out  1  one-cycle pulse: inst updated by a fetch this cycle
- load_start  in  1  begin a program load (IDLE only)
- load_base  in  ADDR_W  first word address of the load, sampled with load_start
- load_valid  in  1  load word present
- load_data  in  DATA_W  load word
- load_last  in  1  marks final word of the load, qualified by load_valid
- load_ready  out  1  block accepts a load word
- busy  out  1  high in CLEAR or LOAD
- load_count  out  ADDR_W+1  words written by current/last load
- load_err  out  1  sticky: load ran past DEPTH-1 without load_last

## Operation
- States: CLEAR, IDLE, LOAD. Reset enters CLEAR (macro defined) or IDLE.
- CLEAR: counter 0..DEPTH-1 writes NOP_WORD one word per cycle; after word DEPTH-1 -> IDLE. Inputs ignored.
- IDLE: en_read=1 -> inst<=mem[pc] (or HALT_WORD if pc>=DEPTH), inst_valid<=1; en_read=0 -> inst holds, inst_valid<=0.
- IDLE + load_start -> LOAD; ptr<=load_base, load_count<=0, load_err<=0. load_base>=DEPTH: load_err<=1, stay IDLE.
- LOAD: load_ready=1. On load_valid: mem[ptr]<=load_data, ptr++, load_count++. If load_last -> IDLE. Else if ptr==DEPTH-1 -> load_err<=1, IDLE (word at DEPTH-1 is written; no wrap to 0).
- Fetch outside IDLE: ignored, inst holds, inst_valid=0. load_start outside IDLE ignored.
- en_read and load_start same IDLE cycle: fetch served from pre-load contents, then LOAD.
- load_ready=0 outside LOAD; load_valid then has no effect.

## Timing
- Fetch latency 1 cycle: pc at edge N -> inst/inst_valid visible after edge N.
- Load throughput 1 word/cycle; LOAD->IDLE on the edge accepting the last word; first fetch from IDLE next cycle sees new data.
- CLEAR lasts exactly DEPTH cycles after rst deasserts.
- Reset values: inst=NOP_WORD, inst_valid=0, load_ready=0, load_count=0, load_err=0, busy=1 (macro) or 0.
- Reset mid-LOAD/CLEAR: abort next edge; words already written retained (overwritten by CLEAR if macro defined).

## Configuration
- INST_MEM_CLEAR_EN defined: reset -> CLEAR sweep, busy high DEPTH cycles, all words NOP_WORD before first fetch.
- Undefined: reset -> IDLE directly, busy=0, memory contents untouched by reset (simulation X until loaded).

## Test plan
- Reset with INST_MEM_CLEAR_EN, DEPTH=32 -> busy high 32 cycles; fetch pc=7 -> inst=32'h1000_0000, inst_valid 1 cycle later.
- load_start base=0, stream 23 GCD words, load_last on 23rd -> load_count=23, busy drops; fetch pc=1 -> inst=32'h4000_03ED? no—expected mem[1] word; pc=22 -> 32'h0.
- load_start base=30, 4 words no load_last -> words 30,31 written, load_err=1, load_count=2, load_ready=0 thereafter.
- DEPTH=20, fetch pc=25 -> inst=HALT_WORD, inst_valid=1; load_base=21 -> load_err=1, stays IDLE.
- en_read during LOAD -> inst unchanged, inst_valid=0; en_read+load_start same cycle -> old mem[pc] returned, then LOAD.
- rst asserted after 3 load words -> state IDLE/CLEAR next edge, load_count=0, load_err=0, inst=NOP_WORD.
